// File: rtl/bch_enroll_ctrl_pkg.sv
// rtl/bch_enroll_ctrl_pkg.sv - shared state encodings and helpers for the BCH controllers
//
// Purpose: state type shared by the BCH enroll/decode sequencers, plus a
// constant-evaluable ceil-divide used to size the ECC word count.
package bch_enroll_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EN_WAIT = 3'd1,
        S_FETCH   = 3'd2,
        S_START   = 3'd3,
        S_WAIT_WR = 3'd4,
        S_NEXT    = 3'd5,
        S_DONE    = 3'd6,
        S_ERR     = 3'd7
    } state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/bch_timeout_cnt.sv
// rtl/bch_timeout_cnt.sv - loadable down-counter with expire flag
//
// Purpose: watchdog counter. Load takes priority over counting; the count
// saturates at zero, where O_expired stays high until the next load.
// Ports:
//   I_clk, I_rst   clock, synchronous active-high reset
//   I_load         load I_load_val this cycle
//   I_en           count down by one when not loading
//   I_load_val     reload value
//   O_expired      count has reached zero
module bch_timeout_cnt #(
    parameter int C_WIDTH = 10
) (
    input  logic               I_clk,
    input  logic               I_rst,
    input  logic               I_load,
    input  logic               I_en,
    input  logic [C_WIDTH-1:0] I_load_val,
    output logic               O_expired
);

    logic [C_WIDTH-1:0] r_cnt;

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_cnt <= '0;
        end else if (I_load) begin
            r_cnt <= I_load_val;
        end else if (I_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign O_expired = (r_cnt == '0);

endmodule

// File: rtl/bch_enroll_ctrl.sv
// rtl/bch_enroll_ctrl.sv - enrollment sequencer for the BCH encoder wrapper
//
// Purpose: fetches C_NUM_BLOCKS response words, starts the encoder wrapper
// once per block, waits for its ECC writes and steps the helper base address.
// Ports:
//   I_clk, I_rst          clock, synchronous active-high reset
//   I_go, I_abort         start (IDLE/ERR only) / return to IDLE
//   I_src_valid/_data     upstream response word, O_src_ready accepts it
//   O_enc_data/_start/_en/_base  encoder wrapper controls
//   I_enc_wen             wrapper helper-memory write strobe
//   O_busy/_done/_err     status to the top-level controller
//   O_blk_cnt             current block index
module bch_enroll_ctrl
    import bch_enroll_ctrl_pkg::*;
#(
    parameter int C_DATA_BITS     = 16,
    parameter int C_ECC_BITS      = 20,
    parameter int C_MEM_ADDR_SIZE = 10,
    parameter int C_MEM_DATA_SIZE = 8,
    parameter int C_NUM_BLOCKS    = 4,
    parameter int C_BASE_ADDR     = 16,
    parameter int C_TIMEOUT       = 1023
) (
    input  logic                       I_clk,
    input  logic                       I_rst,
    input  logic                       I_go,
    input  logic                       I_abort,
    input  logic                       I_src_valid,
    input  logic [C_DATA_BITS-1:0]     I_src_data,
    output logic                       O_src_ready,
    output logic [C_DATA_BITS-1:0]     O_enc_data,
    output logic                       O_enc_start,
    output logic                       O_enc_en,
    output logic [C_MEM_ADDR_SIZE-1:0] O_enc_base,
    input  logic                       I_enc_wen,
    output logic                       O_busy,
    output logic                       O_done,
    output logic                       O_err,
    output logic [7:0]                 O_blk_cnt
);

    localparam int LP_ECC_WORDS = ceil_div(C_ECC_BITS, C_MEM_DATA_SIZE);
    localparam int LP_TO_W      = $clog2(C_TIMEOUT + 1);

    localparam logic [LP_TO_W-1:0]         LP_TO_LOAD   = LP_TO_W'(C_TIMEOUT - 1);
    localparam logic [7:0]                 LP_WEN_LAST  = 8'(LP_ECC_WORDS - 1);
    localparam logic [7:0]                 LP_BLK_LAST  = 8'(C_NUM_BLOCKS - 1);
    localparam logic [C_MEM_ADDR_SIZE-1:0] LP_BASE      = C_MEM_ADDR_SIZE'(C_BASE_ADDR);
    localparam logic [C_MEM_ADDR_SIZE-1:0] LP_BASE_STEP = C_MEM_ADDR_SIZE'(LP_ECC_WORDS);

    state_t                     r_state;
    state_t                     w_next;
    logic                       r_hold;      // second cycle of EN_WAIT / START
    logic [7:0]                 r_wen_cnt;
    logic [7:0]                 r_blk_cnt;
    logic [C_MEM_ADDR_SIZE-1:0] r_base;
    logic [C_DATA_BITS-1:0]     r_data;
    logic                       r_err;

    logic w_hs;
    logic w_wen;
    logic w_last_wen;
    logic w_expired;
    logic w_to_load;
    logic w_to_en;

    // Expiry is measured from the last write (or from WAIT_WR entry): the
    // counter is held loaded outside WAIT_WR and reloaded on every strobe.
    assign w_to_load = (r_state != S_WAIT_WR) || I_enc_wen;
    assign w_to_en   = (r_state == S_WAIT_WR);

    bch_timeout_cnt #(
        .C_WIDTH (LP_TO_W)
    ) u_timeout (
        .I_clk      (I_clk),
        .I_rst      (I_rst),
        .I_load     (w_to_load),
        .I_en       (w_to_en),
        .I_load_val (LP_TO_LOAD),
        .O_expired  (w_expired)
    );

    always_comb begin
        w_next     = r_state;
        w_hs       = (r_state == S_FETCH) && I_src_valid;
        w_wen      = (r_state == S_WAIT_WR) && I_enc_wen;
        w_last_wen = w_wen && (r_wen_cnt == LP_WEN_LAST);
        case (r_state)
            S_IDLE, S_ERR: if (I_go) w_next = S_EN_WAIT;
            S_EN_WAIT:     if (r_hold) w_next = S_FETCH;
            S_FETCH:       if (w_hs) w_next = S_START;
            S_START:       if (r_hold) w_next = S_WAIT_WR;
            S_WAIT_WR: begin
                // A strobe in the expiry cycle wins over the timeout.
                if (w_last_wen) begin
                    w_next = S_NEXT;
                end else if (!w_wen && w_expired) begin
                    w_next = S_ERR;
                end
            end
            S_NEXT:        w_next = (r_blk_cnt == LP_BLK_LAST) ? S_DONE : S_FETCH;
            S_DONE:        w_next = S_IDLE;
            default:       w_next = S_IDLE;
        endcase
        if (I_abort) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_state   <= S_IDLE;
            r_hold    <= 1'b0;
            r_wen_cnt <= '0;
            r_blk_cnt <= '0;
            r_base    <= LP_BASE;
            r_data    <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_hold  <= ((r_state == S_EN_WAIT) || (r_state == S_START)) && !r_hold && !I_abort;

            if (r_state != S_WAIT_WR) begin
                r_wen_cnt <= '0;
            end else if (w_wen) begin
                r_wen_cnt <= r_wen_cnt + 8'd1;
            end

            // The word is consumed on the handshake even if an abort lands
            // in the same cycle, so capture it regardless.
            if (w_hs) begin
                r_data <= I_src_data;
            end

            if (!I_abort) begin
                if (((r_state == S_IDLE) || (r_state == S_ERR)) && I_go) begin
                    r_blk_cnt <= '0;
                    r_base    <= LP_BASE;
                    r_err     <= 1'b0;
                end
                if (r_state == S_NEXT) begin
                    r_base <= r_base + LP_BASE_STEP;
                    if (r_blk_cnt != LP_BLK_LAST) begin
                        r_blk_cnt <= r_blk_cnt + 8'd1;
                    end
                end
                if (w_next == S_ERR) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign O_busy      = (r_state != S_IDLE) && (r_state != S_ERR);
    assign O_enc_en    = O_busy;
    assign O_src_ready = (r_state == S_FETCH);
    assign O_enc_start = (r_state == S_START);
    assign O_done      = (r_state == S_DONE);
    assign O_err       = r_err;
    assign O_enc_data  = r_data;
    assign O_enc_base  = r_base;
    assign O_blk_cnt   = r_blk_cnt;

endmodule

// File: tb/tb_bch_enroll_ctrl.sv
// tb/tb_bch_enroll_ctrl.sv - self-checking bench for bch_enroll_ctrl
module tb_bch_enroll_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        go = 1'b0;
    logic        abort = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] data = 16'h0;
    logic        wen = 1'b0;
    int          sel = 0;
    logic [2:0]  go_v;

    logic        o_ready [3];
    logic [15:0] o_data  [3];
    logic        o_start [3];
    logic        o_en    [3];
    logic [9:0]  o_base  [3];
    logic        o_busy  [3];
    logic        o_done  [3];
    logic        o_err   [3];
    logic [7:0]  o_blk   [3];

    int n_tests = 0;
    int n_fail  = 0;
    int n_start_rise = 0;
    int n_done0 = 0;
    logic st_prev = 1'b0;

    always #5 clk = ~clk;

    assign go_v = go ? (3'b001 << sel) : 3'b000;

    bch_enroll_ctrl u_dut0 (
        .I_clk(clk), .I_rst(rst), .I_go(go_v[0]), .I_abort(abort),
        .I_src_valid(valid), .I_src_data(data), .O_src_ready(o_ready[0]),
        .O_enc_data(o_data[0]), .O_enc_start(o_start[0]), .O_enc_en(o_en[0]),
        .O_enc_base(o_base[0]), .I_enc_wen(wen), .O_busy(o_busy[0]),
        .O_done(o_done[0]), .O_err(o_err[0]), .O_blk_cnt(o_blk[0])
    );

    bch_enroll_ctrl #(.C_NUM_BLOCKS(1)) u_dut1 (
        .I_clk(clk), .I_rst(rst), .I_go(go_v[1]), .I_abort(abort),
        .I_src_valid(valid), .I_src_data(data), .O_src_ready(o_ready[1]),
        .O_enc_data(o_data[1]), .O_enc_start(o_start[1]), .O_enc_en(o_en[1]),
        .O_enc_base(o_base[1]), .I_enc_wen(wen), .O_busy(o_busy[1]),
        .O_done(o_done[1]), .O_err(o_err[1]), .O_blk_cnt(o_blk[1])
    );

    bch_enroll_ctrl #(.C_NUM_BLOCKS(2), .C_BASE_ADDR(1022)) u_dut2 (
        .I_clk(clk), .I_rst(rst), .I_go(go_v[2]), .I_abort(abort),
        .I_src_valid(valid), .I_src_data(data), .O_src_ready(o_ready[2]),
        .O_enc_data(o_data[2]), .O_enc_start(o_start[2]), .O_enc_en(o_en[2]),
        .O_enc_base(o_base[2]), .I_enc_wen(wen), .O_busy(o_busy[2]),
        .O_done(o_done[2]), .O_err(o_err[2]), .O_blk_cnt(o_blk[2])
    );

    always @(posedge clk) begin
        st_prev <= o_start[0];
        if (o_start[0] && !st_prev) n_start_rise <= n_start_rise + 1;
        if (o_done[0]) n_done0 <= n_done0 + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        go;
        logic        valid;
        logic [15:0] data;
        logic        wen;
        logic [5:0]  flags;   // {ready, start, en, busy, done, err}
        logic [9:0]  base;
        logic [7:0]  blk;
        logic [15:0] edata;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] snap(input int s);
        return {o_ready[s], o_start[s], o_en[s], o_busy[s], o_done[s], o_err[s],
                o_base[s], o_blk[s], o_data[s]};
    endfunction

    task automatic pulse_go();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!o_ready[sel] && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("ready_seen", 64'(o_ready[sel]), 64'd1);
    endtask

    // Returns at the negedge right after the edge that sampled the last wen.
    task automatic do_block(input logic [15:0] d, input int exp_base, input int exp_blk, input int nwen);
        wait_ready();
        repeat (3) @(negedge clk);
        valid = 1'b1;
        data  = d;
        @(negedge clk);
        valid = 1'b0;
        check("start_hi_c1", 64'(o_start[sel]), 64'd1);
        check("enc_data", 64'(o_data[sel]), 64'(d));
        check("enc_base", 64'(o_base[sel]), 64'(exp_base));
        check("blk_cnt", 64'(o_blk[sel]), 64'(exp_blk));
        @(negedge clk);
        check("start_hi_c2", 64'(o_start[sel]), 64'd1);
        @(negedge clk);
        check("start_lo", 64'(o_start[sel]), 64'd0);
        for (int i = 0; i < nwen; i++) begin
            wen = 1'b1;
            @(negedge clk);
            wen = 1'b0;
            if (i < nwen - 1) @(negedge clk);
        end
    endtask

    initial begin
        int s0;
        int d0;
        int k;

        tbl[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 6'b000000, 10'd16, 8'd0, 16'h0000};
        tbl[1]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 6'b001100, 10'd16, 8'd0, 16'h0000};
        tbl[2]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 6'b001100, 10'd16, 8'd0, 16'h0000};
        tbl[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 6'b101100, 10'd16, 8'd0, 16'h0000};
        tbl[4]  = '{1'b0, 1'b1, 16'hA5C3, 1'b0, 6'b101100, 10'd16, 8'd0, 16'h0000};
        tbl[5]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 6'b011100, 10'd16, 8'd0, 16'hA5C3};
        tbl[6]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 6'b011100, 10'd16, 8'd0, 16'hA5C3};
        tbl[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 6'b001100, 10'd16, 8'd0, 16'hA5C3};
        tbl[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 6'b001100, 10'd16, 8'd0, 16'hA5C3};
        tbl[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 6'b001100, 10'd16, 8'd0, 16'hA5C3};
        tbl[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 6'b001100, 10'd16, 8'd0, 16'hA5C3};
        tbl[11] = '{1'b0, 1'b0, 16'h0000, 1'b0, 6'b001110, 10'd19, 8'd0, 16'hA5C3};
        tbl[12] = '{1'b0, 1'b0, 16'h0000, 1'b0, 6'b000000, 10'd19, 8'd0, 16'hA5C3};

        // reset
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_dut0", 64'(snap(0)), 64'({6'b000000, 10'd16, 8'd0, 16'h0}));
        check("reset_dut2_base", 64'(o_base[2]), 64'd1022);

        // single-block run, cycle by cycle
        sel = 1;
        for (int i = 0; i < 13; i++) begin
            check($sformatf("vec%0d", i), 64'(snap(1)),
                  64'({tbl[i].flags, tbl[i].base, tbl[i].blk, tbl[i].edata}));
            go    = tbl[i].go;
            valid = tbl[i].valid;
            data  = tbl[i].data;
            wen   = tbl[i].wen;
            @(negedge clk);
        end
        go = 1'b0; valid = 1'b0; wen = 1'b0;

        // full four-block enrollment
        sel = 0;
        s0 = n_start_rise;
        d0 = n_done0;
        pulse_go();
        for (int b = 0; b < 4; b++) begin
            do_block(16'h1000 + 16'(b), 16 + 3 * b, b, 3);
        end
        check("t1_next_no_done", 64'(o_done[0]), 64'd0);
        @(negedge clk);
        check("t1_done", 64'(o_done[0]), 64'd1);
        check("t1_blk_final", 64'(o_blk[0]), 64'd3);
        check("t1_base_final", 64'(o_base[0]), 64'd28);
        @(negedge clk);
        check("t1_idle", 64'({o_busy[0], o_done[0], o_en[0]}), 64'd0);
        check("t1_start_edges", 64'(n_start_rise - s0), 64'd4);
        check("t1_done_pulses", 64'(n_done0 - d0), 64'd1);

        // timeout in block 1
        pulse_go();
        do_block(16'h2000, 16, 0, 3);
        do_block(16'h2001, 19, 1, 2);
        k = 0;
        while (!o_err[0] && k < 1100) begin
            @(negedge clk);
            k++;
        end
        check("t3_timeout_cycles", 64'(k), 64'd1023);
        check("t3_err_state", 64'({o_err[0], o_en[0], o_busy[0]}), 64'b100);
        pulse_go();
        check("t3_restart", 64'({o_err[0], o_busy[0], o_base[0], o_blk[0]}),
              64'({1'b0, 1'b1, 10'd16, 8'd0}));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t3_abort_idle", 64'({o_busy[0], o_err[0]}), 64'd0);

        // abort during WAIT_WR of block 2
        d0 = n_done0;
        pulse_go();
        do_block(16'h3000, 16, 0, 3);
        do_block(16'h3001, 19, 1, 3);
        do_block(16'h3002, 22, 2, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t4_abort", 64'({o_busy[0], o_en[0], o_err[0], o_base[0]}),
              64'({3'b000, 10'd22}));
        repeat (5) @(negedge clk);
        check("t4_no_done", 64'(n_done0 - d0), 64'd0);
        go = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        go = 1'b0;
        abort = 1'b0;
        check("t4_go_abort_same", 64'(o_busy[0]), 64'd0);

        // base address wrap
        sel = 2;
        pulse_go();
        do_block(16'h6000, 1022, 0, 3);
        do_block(16'h6001, 1, 1, 3);
        check("t5_next_no_done", 64'(o_done[2]), 64'd0);
        @(negedge clk);
        check("t5_done", 64'(o_done[2]), 64'd1);
        check("t5_base_final", 64'(o_base[2]), 64'd4);

        // go and wen in FETCH are ignored; reset mid-START
        sel = 0;
        pulse_go();
        wait_ready();
        go = 1'b1;
        wen = 1'b1;
        @(negedge clk);
        go = 1'b0;
        wen = 1'b0;
        check("t6_fetch_hold", 64'({o_ready[0], o_busy[0], o_blk[0]}), 64'({2'b11, 8'd0}));
        valid = 1'b1;
        data  = 16'h4444;
        @(negedge clk);
        valid = 1'b0;
        check("t6_start", 64'(o_start[0]), 64'd1);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            wen = 1'b1;
            @(negedge clk);
            wen = 1'b0;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        check("t6_two_wen_no_advance", 64'({o_base[0], o_en[0], o_start[0]}),
              64'({10'd16, 2'b10}));
        wen = 1'b1;
        @(negedge clk);
        wen = 1'b0;
        @(negedge clk);
        check("t6_third_wen_advance", 64'({o_base[0], o_ready[0]}), 64'({10'd19, 1'b1}));
        valid = 1'b1;
        data  = 16'h5555;
        @(negedge clk);
        valid = 1'b0;
        check("t6_start_blk1", 64'(o_start[0]), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_rst_mid_start", 64'(snap(0)), 64'({6'b000000, 10'd16, 8'd0, 16'h0}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bch_enroll_ctrl.md
Name: bch_enroll_ctrl

Overview:
Sequencer for the BCH encoder wrapper used during PUF enrollment. It fetches C_NUM_BLOCKS response words from an upstream source and hands each one to the encoder wrapper with a start edge. It waits until the block's ECC words have been written to helper memory, then advances the helper-data base address for the next block. It reports done or error to the top-level controller.

Parameters:
C_DATA_BITS, 16, BCH data bits per block; must equal the wrapper's data width
C_ECC_BITS, 20, BCH ECC bits per block
C_MEM_ADDR_SIZE, 10, helper-memory address width
C_MEM_DATA_SIZE, 8, helper-memory word width
C_NUM_BLOCKS, 4, blocks per enrollment, 1..255
C_BASE_ADDR, 16, helper address of block 0's first ECC word
C_TIMEOUT, 1023, max cycles between events in WAIT_WR before error

Ports:
I_clk  in  1  clock
I_rst  in  1  synchronous, active-high reset
I_go  in  1  start enrollment; sampled only in IDLE/ERR
I_abort  in  1  return to IDLE from any state
I_src_valid  in  1  upstream data valid
I_src_data  in  C_DATA_BITS  upstream response block
O_src_ready  out  1  upstream accept
O_enc_data  out  C_DATA_BITS  registered data to the wrapper
O_enc_start  out  1  start level to the wrapper
O_enc_en  out  1  wrapper enable; low clears the wrapper
O_enc_base  out  C_MEM_ADDR_SIZE  helper base address of the current block
I_enc_wen  in  1  wrapper memory write strobe, one per ECC word
O_busy  out  1  high in any state other than IDLE/ERR
O_done  out  1  one-cycle pulse on completion
O_err  out  1  sticky timeout flag
O_blk_cnt  out  8  index of the current block

Behaviour:
- Local constant LP_ECC_WORDS = ceil(C_ECC_BITS / C_MEM_DATA_SIZE); with the defaults it is 3.
- Reset values: state IDLE; all outputs 0, except O_enc_base = C_BASE_ADDR.
- IDLE: O_enc_en=0. I_go -> EN_WAIT; clear blk_cnt; O_enc_base <= C_BASE_ADDR; clear O_err.
- EN_WAIT: O_enc_en=1 for 2 cycles so the wrapper's enable register settles -> FETCH.
- FETCH: O_src_ready=1. On I_src_valid&O_src_ready, O_enc_data <= I_src_data -> START.
  - O_src_ready is combinational from state.
  - Waiting for I_src_valid has no timeout.
- START: O_enc_start=1 for exactly 2 cycles, covering the wrapper's edge detector plus its ready qualification -> WAIT_WR with O_enc_start=0.
  - O_enc_start is low in every other state, so each block gets exactly one rising edge.
- WAIT_WR: count I_enc_wen pulses.
  - When the count reaches LP_ECC_WORDS -> NEXT.
  - The timeout counter reloads on entry and on every I_enc_wen.
  - If the timeout counter reaches C_TIMEOUT with no I_enc_wen -> ERR.
- NEXT (1 cycle): O_enc_base += LP_ECC_WORDS, truncated to C_MEM_ADDR_SIZE (wraps silently).
  - If blk_cnt == C_NUM_BLOCKS-1 -> DONE; otherwise blk_cnt++ -> FETCH.
- DONE (1 cycle): O_done=1 -> IDLE. blk_cnt and O_enc_base hold their final values until the next I_go.
- ERR: O_err=1, O_enc_en=0, O_busy=0. I_go restarts as from IDLE and clears O_err; I_rst also clears it.
- I_abort overrides every transition except I_rst. Next state is IDLE, O_enc_en drops the following cycle, O_err is unchanged, and no O_done is issued.
- I_go while busy is ignored.
- I_enc_wen outside WAIT_WR is ignored; it is not counted.
- I_go and I_abort in the same cycle: I_abort wins.
- Simultaneous I_enc_wen and timeout expiry: the I_enc_wen wins and the timeout counter reloads.

Decomposition:
- Shared package/header bch_ctrl_defs.vh holds:
  - state encodings (IDLE, EN_WAIT, FETCH, START, WAIT_WR, NEXT, DONE, ERR; 3-bit);
  - a ceil-divide macro for LP_ECC_WORDS.
- One sub-module, bch_timeout_cnt: loadable down-counter with reload, enable and expire outputs, reusable by the decoder controller.

Test Plan:
- Defaults, I_go, each source word valid 3 cycles after O_src_ready, wen modelled 3 times per block -> 4 start edges; O_enc_base 16, 19, 22, 25; O_done 1 cycle after the 12th counted wen; O_blk_cnt ends at 3.
- C_NUM_BLOCKS=1, I_src_data=16'hA5C3 -> O_enc_data=16'hA5C3 on the cycle O_enc_start rises; O_enc_start high exactly 2 cycles; O_done after the 3rd wen.
- Block 1 stops at 2 wens -> ERR exactly C_TIMEOUT cycles after the 2nd wen; O_err=1, O_enc_en=0, O_busy=0; a subsequent I_go restarts with O_enc_base=16 and O_err=0.
- I_abort during WAIT_WR of block 2 -> IDLE next cycle; O_enc_en=0; no O_done; O_enc_base holds 22.
- C_BASE_ADDR=1022, C_NUM_BLOCKS=2 -> block 1 base = (1022+3) mod 1024 = 1.
- I_go pulsed in FETCH and a spurious wen in FETCH -> no state change and no wen counted; I_rst mid-START -> all outputs return to reset values next cycle.
